// File: rtl/helix_thought_arbiter.sv
// helix_thought_arbiter: N_REQ-to-1 thought arbiter with a registered output slot.
// Define HELIX_ARB_QUOTA_EN for burst-quota arbitration; otherwise plain round-robin.
`ifndef HELIX_THOUGHT_W
`define HELIX_THOUGHT_W 8
`endif
module helix_thought_arbiter #(
  parameter int N_REQ     = 4,
  parameter int THOUGHT_W = `HELIX_THOUGHT_W,
  parameter int QUOTA     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*THOUGHT_W-1:0]   req_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [THOUGHT_W-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0]     out_src
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(QUOTA + 1);
`ifdef HELIX_ARB_QUOTA_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  logic                 out_valid_q, out_valid_d;
  logic [THOUGHT_W-1:0] out_data_q, out_data_d;
  logic [PW-1:0]        out_src_q, out_src_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        win, win_inc;
  logic                 load, any, xfer;
  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr_q) + k) % N_REQ]) win = PW'((int'(ptr_q) + k) % N_REQ);
  end
  always_comb begin
    win_inc     = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
    any         = |req_valid;
    load        = ~out_valid_q | out_ready;
    xfer        = load & any & ~rst;
    req_ready   = xfer ? (N_REQ'(1) << win) : '0;
    out_valid_d = xfer | (out_valid_q & ~out_ready);
    out_data_d  = xfer ? req_data[win*THOUGHT_W +: THOUGHT_W] : out_data_q;
    out_src_d   = xfer ? win : out_src_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (xfer) begin
      if (!QEN || (win == ptr_q && 32'(cnt_q) + 1 == QUOTA) || (win != ptr_q && QUOTA == 1)) begin
        ptr_d = win_inc;
        cnt_d = '0;
      end else if (win == ptr_q) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        ptr_d = win;
        cnt_d = CW'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
endmodule
